// File: rtl/esc_cmd_sequencer_if.sv
// Command handshake bundle for the ESC sequencer: valid/ready transfer of a signed period target.
interface esc_cmd_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic signed [DATA_WIDTH-1:0] cmd_target;

  modport master (output cmd_valid, output cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, output cmd_ready);
endinterface

// File: rtl/esc_cmd_sequencer.sv
// ESC command sequencer: all outputs registered, each decision appears one clk after its edge.
// cmd_ready is low outside IDLE/RUN; stall detection and FAULT exist only with ESC_STALL_DETECT_EN.
module esc_cmd_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int RAMP_DIV     = 1024,
  parameter int RAMP_STEP    = 64,
  parameter int DEAD_CYCLES  = 4096,
  parameter int STALL_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  esc_cmd_if.slave                     cmd,
  input  logic                         encoder_a,
  input  logic                         fault_clear,
  output logic                         pwm_en,
  output logic signed [DATA_WIDTH-1:0] period_reference,
  output logic                         fault,
  output logic [2:0]                   state
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] RAMP  = 3'd2;
  localparam logic [2:0] DEAD  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]             DIV_LAST  = DIV_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]            DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
  localparam logic [DATA_WIDTH:0]          STEP_W    = (DATA_WIDTH+1)'(RAMP_STEP);
  localparam logic signed [DATA_WIDTH-1:0] STEP_D    = DATA_WIDTH'(RAMP_STEP);

  logic signed [DATA_WIDTH-1:0] ramp_target;
  logic signed [DATA_WIDTH-1:0] pending;
  logic [DIV_W-1:0]             div_cnt;
  logic [DEAD_W-1:0]            dead_cnt;
  logic                         accept;
  logic                         tgt_zero;
  logic                         tgt_same_sign;
  logic                         ramp_tick;
  logic                         dead_done;
  logic                         stall_hit;
  logic                         clear_req;
  logic signed [DATA_WIDTH:0]   ramp_diff;
  logic [DATA_WIDTH:0]          ramp_abs;
  logic                         ramp_close;
  logic signed [DATA_WIDTH-1:0] ramp_next;

  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign tgt_zero      = (cmd.cmd_target == '0);
  assign tgt_same_sign = (cmd.cmd_target[DATA_WIDTH-1] == period_reference[DATA_WIDTH-1]);
  assign ramp_tick     = (div_cnt == DIV_LAST);
  assign dead_done     = (dead_cnt == DEAD_LAST);

  // One extra bit keeps the distance exact across the whole signed range.
  assign ramp_diff  = {ramp_target[DATA_WIDTH-1], ramp_target}
                    - {period_reference[DATA_WIDTH-1], period_reference};
  assign ramp_abs   = ramp_diff[DATA_WIDTH] ? $unsigned(-ramp_diff) : $unsigned(ramp_diff);
  assign ramp_close = (ramp_abs <= STEP_W);
  assign ramp_next  = ramp_diff[DATA_WIDTH] ? (period_reference - STEP_D)
                                            : (period_reference + STEP_D);

`ifdef ESC_STALL_DETECT_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);

  logic               enc_s1;
  logic               enc_s2;
  logic               enc_s3;
  logic               enc_rise;
  logic               stall_active;
  logic [STALL_W-1:0] stall_cnt;

  assign enc_rise     = enc_s2 & ~enc_s3;
  assign stall_active = (state == RUN) || (state == RAMP);
  assign stall_hit    = stall_active && !enc_rise && (stall_cnt >= STALL_LAST);
  assign clear_req    = fault_clear;

  // Held at zero outside RUN/RAMP, so every entry to RUN from IDLE or DEAD starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_s1    <= 1'b0;
      enc_s2    <= 1'b0;
      enc_s3    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      enc_s1 <= encoder_a;
      enc_s2 <= enc_s1;
      enc_s3 <= enc_s2;
      if (!stall_active || enc_rise) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (stall_hit) begin
      fault <= 1'b1;
    end else if ((state == FAULT) && fault_clear) begin
      fault <= 1'b0;
    end
  end
`else
  logic unused_stall;

  assign unused_stall = encoder_a ^ fault_clear ^ (STALL_CYCLES == 0);
  assign stall_hit    = 1'b0;
  assign clear_req    = 1'b0;
  assign fault        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pwm_en           <= 1'b0;
      period_reference <= '0;
      cmd.cmd_ready    <= 1'b0;
      ramp_target      <= '0;
      pending          <= '0;
      div_cnt          <= '0;
      dead_cnt         <= '0;
    end else begin
      cmd.cmd_ready <= 1'b0;
      div_cnt       <= div_cnt + DIV_W'(1);
      dead_cnt      <= dead_cnt + DEAD_W'(1);
      case (state)
        IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (accept && !tgt_zero) begin
            state            <= RUN;
            pwm_en           <= 1'b1;
            period_reference <= cmd.cmd_target;
          end
        end
        RUN: begin
          cmd.cmd_ready <= 1'b1;
          if (stall_hit) begin
            state            <= FAULT;
            pwm_en           <= 1'b0;
            period_reference <= '0;
            cmd.cmd_ready    <= 1'b0;
          end else if (accept && (cmd.cmd_target != period_reference)) begin
            cmd.cmd_ready <= 1'b0;
            if (!tgt_zero && tgt_same_sign) begin
              state       <= RAMP;
              ramp_target <= cmd.cmd_target;
              div_cnt     <= '0;
            end else begin
              // Reversal or stop: coast with drive off before anything new is applied.
              state            <= DEAD;
              pending          <= cmd.cmd_target;
              dead_cnt         <= '0;
              pwm_en           <= 1'b0;
              period_reference <= '0;
            end
          end
        end
        RAMP: begin
          if (stall_hit) begin
            state            <= FAULT;
            pwm_en           <= 1'b0;
            period_reference <= '0;
          end else if (ramp_tick) begin
            div_cnt <= '0;
            if (ramp_close) begin
              state            <= RUN;
              period_reference <= ramp_target;
              cmd.cmd_ready    <= 1'b1;
            end else begin
              period_reference <= ramp_next;
            end
          end
        end
        DEAD: begin
          if (dead_done) begin
            cmd.cmd_ready <= 1'b1;
            if (pending == '0) begin
              state <= IDLE;
            end else begin
              state            <= RUN;
              pwm_en           <= 1'b1;
              period_reference <= pending;
            end
          end
        end
        FAULT: begin
          if (clear_req) begin
            state         <= IDLE;
            cmd.cmd_ready <= 1'b1;
          end
        end
        default: begin
          state            <= IDLE;
          pwm_en           <= 1'b0;
          period_reference <= '0;
        end
      endcase
    end
  end

  // Structural invariants of the output encoding.
  ready_only_idle_run: assert property (@(posedge clk) disable iff (reset)
    cmd.cmd_ready |-> ((state == IDLE) || (state == RUN)));
  drive_off_zero_ref: assert property (@(posedge clk) disable iff (reset)
    !pwm_en |-> (period_reference == '0));
endmodule

// File: tb/tb_esc_cmd_sequencer.sv
// Directed bench for esc_cmd_sequencer: vector table plus hand-written stall/fault sequences.
module tb_esc_cmd_sequencer;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic signed [DW-1:0] cmd_target = '0;
  logic                 enc = 1'b0;
  logic                 enc_auto = 1'b1;
  logic                 fault_clear = 1'b0;
  logic                 pwm_en;
  logic                 fault;
  logic signed [DW-1:0] period_reference;
  logic [2:0]           dut_state;
  int                   errors = 0;
  int                   checks = 0;

  esc_cmd_if #(.DATA_WIDTH(DW)) cmd_bus ();
  assign cmd_bus.cmd_valid  = cmd_valid;
  assign cmd_bus.cmd_target = cmd_target;

  esc_cmd_sequencer #(
    .DATA_WIDTH(DW), .RAMP_DIV(4), .RAMP_STEP(100), .DEAD_CYCLES(8), .STALL_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_bus), .encoder_a(enc), .fault_clear(fault_clear),
    .pwm_en(pwm_en), .period_reference(period_reference), .fault(fault), .state(dut_state)
  );

  always #5 clk = ~clk;

  // Background encoder: toggles every 10 cycles, off the sampling instant of the main thread.
  initial begin
    forever begin
      repeat (10) @(posedge clk);
      #2;
      if (enc_auto) enc = ~enc;
    end
  end

  typedef struct {
    bit rst; bit vld; int tgt; int reps;
    int st; int pwm; int rv; int rdy;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int t, input int n,
                     input int st, input int pwm, input int rv, input int rdy);
    vec_t x;
    x.rst = r; x.vld = v; x.tgt = t; x.reps = n;
    x.st = st; x.pwm = pwm; x.rv = rv; x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input int pwm, input int rv,
                          input int rdy, input int flt);
    chk({tag, " state"}, int'(dut_state), st);
    chk({tag, " pwm_en"}, int'(pwm_en), pwm);
    chk({tag, " period_reference"}, int'(period_reference), rv);
    chk({tag, " cmd_ready"}, int'(cmd_bus.cmd_ready), rdy);
    chk({tag, " fault"}, int'(fault), flt);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //  rst vld target reps | state pwm ref rdy
    add(1, 0, 0,     2,  0, 0, 0,     0);
    add(0, 0, 0,     1,  0, 0, 0,     1);
    add(0, 1, 0,     2,  0, 0, 0,     1);
    add(0, 1, 1000,  1,  1, 1, 1000,  1);
    add(0, 1, 1000,  2,  1, 1, 1000,  1);
    add(0, 1, 1250,  1,  2, 1, 1000,  0);
    add(0, 0, 0,     3,  2, 1, 1000,  0);
    add(0, 0, 0,     1,  2, 1, 1100,  0);
    add(0, 1, -5,    3,  2, 1, 1100,  0);
    add(0, 0, 0,     1,  2, 1, 1200,  0);
    add(0, 0, 0,     3,  2, 1, 1200,  0);
    add(0, 0, 0,     1,  1, 1, 1250,  1);
    add(0, 1, 1000,  1,  2, 1, 1250,  0);
    add(0, 0, 0,     3,  2, 1, 1250,  0);
    add(0, 0, 0,     1,  2, 1, 1150,  0);
    add(0, 0, 0,     3,  2, 1, 1150,  0);
    add(0, 0, 0,     1,  2, 1, 1050,  0);
    add(0, 0, 0,     3,  2, 1, 1050,  0);
    add(0, 0, 0,     1,  1, 1, 1000,  1);
    add(0, 1, -800,  1,  3, 0, 0,     0);
    add(0, 0, 0,     7,  3, 0, 0,     0);
    add(0, 0, 0,     1,  1, 1, -800,  1);
    add(0, 1, 0,     1,  3, 0, 0,     0);
    add(0, 0, 0,     7,  3, 0, 0,     0);
    add(0, 0, 0,     1,  0, 0, 0,     1);
    add(0, 1, -300,  1,  1, 1, -300,  1);
    add(0, 1, -420,  1,  2, 1, -300,  0);
    add(0, 0, 0,     3,  2, 1, -300,  0);
    add(0, 0, 0,     1,  2, 1, -400,  0);
    add(0, 0, 0,     3,  2, 1, -400,  0);
    add(0, 0, 0,     1,  1, 1, -420,  1);
    add(0, 1, 500,   1,  3, 0, 0,     0);
    add(0, 0, 0,     7,  3, 0, 0,     0);
    add(0, 0, 0,     1,  1, 1, 500,   1);
    add(0, 1, 600,   1,  2, 1, 500,   0);
    add(0, 0, 0,     3,  2, 1, 500,   0);
    add(0, 0, 0,     1,  1, 1, 600,   1);
    add(0, 1, 900,   1,  2, 1, 600,   0);
    add(0, 0, 0,     2,  2, 1, 600,   0);
    add(1, 0, 0,     1,  0, 0, 0,     0);
    add(0, 0, 0,     1,  0, 0, 0,     1);
    add(0, 1, 700,   1,  1, 1, 700,   1);
    add(0, 1, -700,  1,  3, 0, 0,     0);
    add(0, 0, 0,     3,  3, 0, 0,     0);
    add(1, 0, 0,     1,  0, 0, 0,     0);
    add(0, 0, 0,     10, 0, 0, 0,     1);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      cmd_valid  = vecs[i].vld;
      cmd_target = DW'(vecs[i].tgt);
      for (int k = 0; k < vecs[i].reps; k++) begin
        tick(1);
        chk_outs($sformatf("vec%0d.%0d", i, k), vecs[i].st, vecs[i].pwm, vecs[i].rv,
                 vecs[i].rdy, 0);
      end
    end
    reset = 1'b0;
    cmd_valid = 1'b0;

    // Stall timing: a rise is detected two edges after it is sampled and clears the count.
    cmd_valid = 1'b1; cmd_target = 1000; tick(1); cmd_valid = 1'b0;
    chk_outs("stall_run", 1, 1, 1000, 1, 0);
    enc_auto = 1'b0; enc = 1'b0; tick(5);
    enc = 1'b1; tick(10);
    enc = 1'b0; tick(40);
    enc = 1'b1; tick(3);
    chk_outs("edge_at_terminal", 1, 1, 1000, 1, 0);
    tick(49);
    chk_outs("stall_minus1", 1, 1, 1000, 1, 0);
    cmd_valid = 1'b1; cmd_target = 0; tick(1);
`ifdef ESC_STALL_DETECT_EN
    chk_outs("stall_beats_cmd", 4, 0, 0, 0, 1);
    cmd_target = 1000; tick(3);
    chk_outs("fault_ignores_cmd", 4, 0, 0, 0, 1);
    cmd_valid = 1'b0; fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    chk_outs("fault_clear", 0, 0, 0, 1, 0);
    cmd_valid = 1'b1; cmd_target = 1000; tick(1); cmd_valid = 1'b0;
    chk_outs("rerun", 1, 1, 1000, 1, 0);
    tick(49);
    chk_outs("rerun_minus1", 1, 1, 1000, 1, 0);
    tick(1);
    chk_outs("rerun_stall", 4, 0, 0, 0, 1);
    reset = 1'b1; tick(1);
    chk_outs("reset_in_fault", 0, 0, 0, 0, 0);
    reset = 1'b0; tick(1);
    chk_outs("post_fault_reset", 0, 0, 0, 1, 0);
`else
    chk_outs("no_stall_dead", 3, 0, 0, 0, 0);
    cmd_valid = 1'b0; tick(8);
    chk_outs("no_stall_idle", 0, 0, 0, 1, 0);
    cmd_valid = 1'b1; cmd_target = 1000; tick(1); cmd_valid = 1'b0;
    tick(60);
    chk_outs("no_stall_run", 1, 1, 1000, 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
